// File: rtl/packed_sat_accum.sv
// Four-lane packed signed 4-bit saturating accumulator with a valid/ready packet interface.
// Each accepted beat adds into the lane sums; the result is held until the consumer takes it.
module packed_sat_accum #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [3:0]       out_sat,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e           state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [3:0]       sat_q, sat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic [15:0]      base_acc;
  logic [3:0]       base_sat;
  logic [CNT_W-1:0] base_cnt;
  logic [15:0]      beat_sum;
  logic [3:0]       beat_ovf;

  // Returns {overflow, saturated-or-wrapped sum}.
  function automatic logic [4:0] sat4(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] s;
    s = a + b;
    if ((a[3] == b[3]) && (s[3] != a[3])) begin
      return {1'b1, (a[3] ? 4'h8 : 4'h7)};
    end
    return {1'b0, s};
  endfunction

  assign in_ready = (state_q != StHold);
  assign accept   = in_valid & in_ready;

  // The first beat of a packet always starts from a zero accumulator.
  assign base_acc = (state_q == StIdle) ? '0 : acc_q;
  assign base_sat = (state_q == StIdle) ? '0 : sat_q;
  assign base_cnt = (state_q == StIdle) ? '0 : cnt_q;

  always_comb begin
    beat_sum = '0;
    beat_ovf = '0;
    for (int k = 0; k < 4; k++) begin
      {beat_ovf[k], beat_sum[4*k +: 4]} = sat4(base_acc[4*k +: 4], in_data[4*k +: 4]);
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StAccum: begin
        if (accept) begin
          acc_d   = beat_sum;
          sat_d   = base_sat | beat_ovf;
          cnt_d   = (base_cnt == '1) ? base_cnt : base_cnt + CNT_W'(1);
          state_d = in_last ? StHold : StAccum;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
          acc_d   = '0;
          sat_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        acc_d   = '0;
        sat_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      sat_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == StHold);
  assign out_data  = acc_q;
  assign out_sat   = sat_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_packed_sat_accum.sv
// Directed bench for packed_sat_accum: hand-computed lane sums, saturation, hold and reset cases.
module tb_packed_sat_accum;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_data;
  logic [3:0]    out_sat;
  logic [CW-1:0] out_count;

  int n_checks = 0;
  int n_fail   = 0;

  packed_sat_accum #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic check_result(input string tag, input logic [15:0] d, input logic [3:0] s,
                              input logic [CW-1:0] c);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_sat"},   32'(out_sat),   32'(s));
    chk({tag, "_count"}, 32'(out_count), 32'(c));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_cons_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_cons_ready"}, 32'(in_ready),  32'd1);
    chk({tag, "_cons_data"},  32'(out_data),  32'd0);
    chk({tag, "_cons_sat"},   32'(out_sat),   32'd0);
    chk({tag, "_cons_count"}, 32'(out_count), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready),  32'd1);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_sat",   32'(out_sat),   32'd0);
    chk("rst_count", 32'(out_count), 32'd0);

    // Plain two-beat sum; out_valid rises only after the last beat.
    send(16'h1234, 1'b0);
    chk("p1_mid_valid", 32'(out_valid), 32'd0);
    send(16'h1111, 1'b1);
    check_result("p1", 16'h2345, 4'b0000, 8'd2);
    consume("p1");

    // Positive overflow in lane 3.
    send(16'h7000, 1'b0);
    send(16'h1000, 1'b1);
    check_result("pos_ovf", 16'h7000, 4'b1000, 8'd2);
    consume("pos_ovf");

    // Negative overflow in lane 0: -8 + -1.
    send(16'h0008, 1'b0);
    send(16'h000F, 1'b1);
    check_result("neg_ovf", 16'h0008, 4'b0001, 8'd2);
    consume("neg_ovf");

    // Sticky flag, accumulation continues from the clamped value.
    send(16'h0007, 1'b0);
    send(16'h0001, 1'b0);
    chk("sticky_mid_data", 32'(out_data), 32'h0007);
    chk("sticky_mid_sat",  32'(out_sat),  32'h1);
    send(16'h000F, 1'b1);
    check_result("sticky", 16'h0006, 4'b0001, 8'd3);

    // Backpressure in HOLD with in_valid asserted: nothing may be accepted.
    in_valid = 1'b1;
    in_data  = 16'h1111;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_ready", 32'(in_ready), 32'd0);
      tick();
      check_result("hold", 16'h0006, 4'b0001, 8'd3);
    end
    // Release with in_valid still high: the HOLD->IDLE edge must not take a beat.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    chk("rel_valid", 32'(out_valid), 32'd0);
    chk("rel_ready", 32'(in_ready),  32'd1);
    chk("rel_data",  32'(out_data),  32'd0);
    chk("rel_sat",   32'(out_sat),   32'd0);
    chk("rel_count", 32'(out_count), 32'd0);

    // Bubbles in ACCUM leave state untouched.
    send(16'h0001, 1'b0);
    tick();
    tick();
    chk("bub_data",  32'(out_data),  32'h0001);
    chk("bub_count", 32'(out_count), 32'd1);
    chk("bub_valid", 32'(out_valid), 32'd0);
    send(16'h0002, 1'b1);
    check_result("bub", 16'h0003, 4'b0000, 8'd2);
    consume("bub");

    // Mid-packet reset, with a simultaneous last beat that must be ignored.
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h3333;
    in_last  = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_ready", 32'(in_ready),  32'd1);
    chk("mrst_data",  32'(out_data),  32'd0);
    chk("mrst_count", 32'(out_count), 32'd0);
    send(16'h0101, 1'b1);
    check_result("after_rst", 16'h0101, 4'b0000, 8'd1);
    consume("after_rst");

    // Reset while holding a result, with out_ready low.
    send(16'h0005, 1'b1);
    check_result("hrst_pre", 16'h0005, 4'b0000, 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("hrst_valid", 32'(out_valid), 32'd0);
    chk("hrst_ready", 32'(in_ready),  32'd1);
    chk("hrst_data",  32'(out_data),  32'd0);

    // 2^CW + 1 beats: the count must stick at all-ones.
    for (int i = 0; i < (1 << CW); i++) begin
      send(16'h0000, 1'b0);
      if (i == 254) chk("cnt_255", 32'(out_count), 32'd255);
    end
    chk("cnt_256", 32'(out_count), 32'd255);
    send(16'h0000, 1'b1);
    check_result("cnt_sat", 16'h0000, 4'b0000, 8'hFF);
    consume("cnt_sat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/packed_sat_accum.md
PACKED_SAT_ACCUM -- requirements
Module: packed_sat_accum

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the beat-counter width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1, meaning in_data/in_last are valid this cycle.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block accepts a beat this cycle.
REQ-006 The block SHALL have port in_data, input, 16, four packed signed 4-bit lanes, where lane k is bits [4k+3:4k].
REQ-007 The block SHALL have port in_last, input, 1, marking the final beat of a packet.
REQ-008 The block SHALL have port out_valid, output, 1, meaning the packet result is available.
REQ-009 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-010 The block SHALL have port out_data, output, 16, the packed saturated lane sums.
REQ-011 The block SHALL have port out_sat, output, 4, the sticky per-lane saturation flags, where bit k corresponds to lane k.
REQ-012 The block SHALL have port out_count, output, CNT_W, the number of beats accepted in the packet.

Function
REQ-013 The block SHALL implement states IDLE, ACCUM and HOLD, with IDLE as the reset state.
REQ-014 The block SHALL drive in_ready=1 in IDLE and ACCUM, and in_ready=0 in HOLD.
REQ-015 A beat SHALL be accepted iff in_valid and in_ready are both 1 on a clock edge.
REQ-016 On an accepted beat, each lane SHALL update as acc_k <= sat4(acc_k + in_data_k), using signed 4-bit arithmetic.
REQ-017 sat4 SHALL detect overflow when both operand signs are equal and the wrapped-sum sign differs: positive overflow yields 0x7 and negative overflow yields 0x8; without overflow, the wrapped 4-bit sum passes through.
REQ-018 On an accepted beat, out_sat[k] SHALL be set when lane k overflows, and SHALL remain set until the packet is consumed or reset occurs.
REQ-019 Accumulation SHALL continue from the saturated value, with no clamping lock (e.g. 0x7, then +0xF, gives 0x6).
REQ-020 The count SHALL increment by 1 per accepted beat and SHALL saturate at all-ones, never wrapping.
REQ-021 IDLE->ACCUM SHALL occur on an accepted beat with in_last=0.
REQ-022 IDLE->HOLD or ACCUM->HOLD SHALL occur on an accepted beat with in_last=1.
REQ-023 The first beat in IDLE SHALL be added to a zero accumulator, so a single-beat packet outputs in_data unchanged.
REQ-024 out_valid SHALL equal 1 exactly in HOLD, asserting the cycle after the last beat is accepted (latency 1).
REQ-025 out_data, out_sat and out_count SHALL be stable throughout HOLD.
REQ-026 HOLD->IDLE SHALL occur when out_ready=1; the accumulator, out_sat and count SHALL clear to 0 on that edge.
REQ-027 No beat SHALL be accepted on the HOLD->IDLE edge; a new packet SHALL start the following cycle at the earliest.
REQ-028 out_data, out_sat and out_count SHALL reflect the live accumulator in IDLE/ACCUM, but are only meaningful while out_valid=1.
REQ-029 in_valid=0 in ACCUM SHALL hold all state unchanged (bubbles allowed).

Reset
REQ-030 rst=1 SHALL force state to IDLE and set accumulator=0x0000, out_sat=0, count=0, out_valid=0 and in_ready=1 on the same edge, in any state.
REQ-031 rst SHALL take priority over any simultaneous accepted beat or out_ready.
REQ-032 A reset mid-packet SHALL discard partial results; the next beat SHALL start a new packet from zero.

Verification
REQ-033 Bench SHALL drive 0x1234 then 0x1111 (last) and check out_data=0x2345, out_sat=0000 and out_count=2, with out_valid rising one cycle after the last beat.
REQ-034 Bench SHALL drive 0x7000 then 0x1000 (last) and check out_data=0x7000 and out_sat=1000; it SHALL also drive 0x0008 then 0x000F (last) and check out_data=0x0008 and out_sat=0001.
REQ-035 Bench SHALL drive 0x0007, 0x0001 and 0x000F (last) and check out_data=0x0006, out_sat=0001 and out_count=3 (sticky flag, continued accumulation).
REQ-036 Bench SHALL hold out_ready=0 for 3 cycles in HOLD while asserting in_valid, and check out_valid=1, in_ready=0, outputs stable and no beat accepted; it SHALL then assert out_ready and check return to IDLE with outputs cleared.
REQ-037 Bench SHALL accept 2 beats, pulse rst for one cycle, then send 0x0101 (last), and check out_data=0x0101, out_count=1 and out_sat=0000.
REQ-038 Bench SHALL drive 2^CNT_W+1 beats of 0x0000 and check out_count=all-ones with no wrap.
